apb_master_fsm: RTL

APB master sequencer on the APB-clock side of the ICB-to-APB bridge, directly downstream of the asynchronous command FIFO. It pops one 64-bit command word per transfer from the FIFO read port, runs the APB SETUP/ACCESS handshake, and pushes one 33-bit response (error flag plus read data) into the response FIFO for return to the ICB side. It issues one transfer at a time with no outstanding transactions.

---
 rtl/apb_master_fsm.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/apb_master_fsm.sv
// ---------------------------------------------------------------------------
// apb_master_fsm
//   APB master sequencer for the APB-clock side of the ICB-to-APB bridge.
//   Pops one 64-bit command from the command FIFO, runs one APB SETUP/ACCESS
//   transfer, and pushes one 33-bit response {error, rdata} into the
//   response FIFO. Only one transfer is ever in flight.
//
//   Optional feature macro: APB_TIMEOUT_EN
//     Defined   : ACCESS aborts with an error response after TIMEOUT_CYCLES
//                 cycles without pready.
//     Undefined : ACCESS waits indefinitely for pready.
//
// Ports
//   rclk, rrst_n          APB clock, async active-low reset
//   cmd_empty / cmd_ren   command FIFO read side (data valid cycle after ren)
//   cmd_data[63:0]        {wdata[31:0], addr[31:2], reserved, write}
//   rsp_full / rsp_wen    response FIFO write side
//   rsp_data[32:0]        {error, rdata}; rdata is 0 for writes
//   psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr : APB
//   busy                  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module apb_master_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        rclk,
   input  logic        rrst_n,
   input  logic        cmd_empty,
   output logic        cmd_ren,
   input  logic [63:0] cmd_data,
   input  logic        rsp_full,
   output logic        rsp_wen,
   output logic [32:0] rsp_data,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   state_e      state_q;
   logic        psel_q;
   logic        penable_q;
   logic        pwrite_q;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic [32:0] rsp_data_q;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt_q;
`else
   // Parameter is only meaningful with the timeout feature compiled in.
   logic [31:0] unused_tmo_cfg;
   assign unused_tmo_cfg = TIMEOUT_CYCLES;
`endif

   // Reserved command bit carries no meaning.
   logic unused_resv;
   assign unused_resv = cmd_data[1];

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q    <= IDLE;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         rsp_data_q <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (!cmd_empty) state_q <= FETCH;
            end
            FETCH: begin
               // cmd_data is valid this cycle; bus signals go live next cycle.
               paddr_q  <= {cmd_data[31:2], 2'b00};
               pwdata_q <= cmd_data[63:32];
               pwrite_q <= cmd_data[0];
               psel_q   <= 1'b1;
               state_q  <= SETUP;
            end
            SETUP: begin
               penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // psel and penable are both high here, so pready alone
               // qualifies sampling of pslverr/prdata.
               if (pready) begin
                  rsp_data_q <= {pslverr, (pwrite_q ? 32'h0 : prdata)};
                  psel_q     <= 1'b0;
                  penable_q  <= 1'b0;
                  state_q    <= RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (tmo_cnt_q == CNT_LAST) begin
                  rsp_data_q <= {1'b1, 32'h0};
                  psel_q     <= 1'b0;
                  penable_q  <= 1'b0;
                  state_q    <= RESP;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
`endif
            end
            RESP: begin
               if (!rsp_full) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // FIFO strobes are combinational so a ready FIFO is served the same cycle.
   assign cmd_ren  = (state_q == IDLE) && !cmd_empty;
   assign rsp_wen  = (state_q == RESP) && !rsp_full;
   assign busy     = (state_q != IDLE);

   assign psel     = psel_q;
   assign penable  = penable_q;
   assign pwrite   = pwrite_q;
   assign paddr    = paddr_q;
   assign pwdata   = pwdata_q;
   assign rsp_data = rsp_data_q;

endmodule
